// File: rtl/btndebounce.sv
// rtl/btndebounce.sv - synchronize, debounce and edge-detect NBTN button inputs
// Optional auto-repeat of o_press while held: define BTNDEBOUNCE_AUTOREPEAT_EN.
module btndebounce #(
    parameter int NBTN     = 4,
    parameter int CTRBITS  = 20,
    parameter int DEBOUNCE = 1000000,
    parameter int REPEAT   = 50000000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NBTN-1:0] i_btn,
    input  logic [NBTN-1:0] i_ack,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_events,
    output logic            o_int
);

    if (DEBOUNCE < 2 || REPEAT < 2) begin : g_bad_param
        $error("btndebounce: DEBOUNCE and REPEAT must be at least 2");
    end

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [NBTN-1:0] s1;
    logic [NBTN-1:0] s2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= i_btn;
            s2 <= s1;
        end
    end

    for (genvar k = 0; k < NBTN; k++) begin : g_btn
        state_t               state_q, state_d;
        logic [CTRBITS-1:0]   cnt_q, cnt_d;
        logic                 btn_q, btn_d;
        logic                 press_q, press_d;
        logic                 rel_q, rel_d;
`ifdef BTNDEBOUNCE_AUTOREPEAT_EN
        localparam int RBITS = $clog2(REPEAT + 1);
        logic [RBITS-1:0]     rpt_q, rpt_d;
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            btn_d   = btn_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            case (state_q)
                ST_STABLE: begin
                    cnt_d = '0;
                    if (s2[k] != btn_q) begin
                        state_d = ST_PENDING;
                        cnt_d   = CTRBITS'(1);
                    end
                end
                ST_PENDING: begin
                    if (s2[k] == btn_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CTRBITS'(DEBOUNCE - 1)) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        btn_d   = s2[k];
                        press_d = s2[k];
                        rel_d   = ~s2[k];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
`ifdef BTNDEBOUNCE_AUTOREPEAT_EN
            // Repeat phase is anchored to the press edge; a release edge
            // suppresses any coincident repeat so strobes never overlap.
            rpt_d = rpt_q;
            if (!btn_q || rel_d) begin
                rpt_d = '0;
            end else if (rpt_q == RBITS'(REPEAT - 1)) begin
                rpt_d   = '0;
                press_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
`endif
        end

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                btn_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
`ifdef BTNDEBOUNCE_AUTOREPEAT_EN
                rpt_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                btn_q   <= btn_d;
                press_q <= press_d;
                rel_q   <= rel_d;
`ifdef BTNDEBOUNCE_AUTOREPEAT_EN
                rpt_q   <= rpt_d;
`endif
            end
        end

        assign o_btn[k]     = btn_q;
        assign o_press[k]   = press_q;
        assign o_release[k] = rel_q;
    end

    // Set beats clear when a press strobe and an ack coincide.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_events <= '0;
            o_int    <= 1'b0;
        end else begin
            o_events <= (o_events & ~i_ack) | o_press;
            o_int    <= |o_events;
        end
    end

endmodule

// File: tb/tb_btndebounce.sv
// tb/tb_btndebounce.sv - directed self-checking bench for btndebounce
module tb_btndebounce;

    localparam int NBTN     = 4;
    localparam int CTRBITS  = 20;
    localparam int DEBOUNCE = 4;
    localparam int REPEAT   = 16;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [NBTN-1:0] i_btn = '0;
    logic [NBTN-1:0] i_ack = '0;
    logic [NBTN-1:0] o_btn;
    logic [NBTN-1:0] o_press;
    logic [NBTN-1:0] o_release;
    logic [NBTN-1:0] o_events;
    logic            o_int;

    int n_cmp = 0;
    int n_err = 0;

    btndebounce #(
        .NBTN(NBTN), .CTRBITS(CTRBITS), .DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn), .i_ack(i_ack),
        .o_btn(o_btn), .o_press(o_press), .o_release(o_release),
        .o_events(o_events), .o_int(o_int)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    logic [127:0] acc;
    logic [127:0] rep_mask;
    logic [127:0] rep_exp;
    int           n_other;

    initial begin
        // reset state and idle
        tick(3);
        check("rst_btn", o_btn, 0);
        check("rst_strobes", {o_press, o_release}, 0);
        check("rst_events", {o_events, o_int}, 0);
        #2 i_reset = 1'b0;
        tick(1);
        acc = '0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            acc = acc | {o_btn, o_press, o_release, o_events, o_int};
        end
        check("idle_outputs", acc, 0);

        // clean press on button 0
        i_btn[0] = 1'b1;
        tick(5);
        check("b0_not_early", o_btn, 4'b0000);
        tick(1);
        check("b0_btn", o_btn, 4'b0001);
        check("b0_press", o_press, 4'b0001);
        tick(1);
        check("b0_press_single", o_press, 4'b0000);
        check("b0_events", o_events, 4'b0001);
        check("b0_int_lag", o_int, 1'b0);
        tick(1);
        check("b0_int", o_int, 1'b1);

        // bouncing button 1, 3-cycle phases
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) i_btn[1] = ~i_btn[1];
            tick(1);
            acc = acc | {o_btn[1], o_press[1], o_release[1]};
        end
        check("b1_bounce_quiet", acc, 0);
        i_btn[1] = 1'b1;
        tick(5);
        check("b1_not_early", o_btn[1], 1'b0);
        tick(1);
        check("b1_btn", o_btn, 4'b0011);
        check("b1_press", o_press, 4'b0010);
        tick(1);
        check("b1_events", o_events, 4'b0011);

        // selective ack, ack on a clear bit
        i_ack = 4'b0010;
        tick(1);
        i_ack = 4'b0100;
        tick(1);
        check("ack_b1", o_events, 4'b0001);
        i_ack = 4'b0000;
        tick(1);
        check("ack_clear_bit", o_events, 4'b0001);

        // release button 0, then re-press with ack on the press cycle
        i_btn[0] = 1'b0;
        tick(6);
        check("b0_release", o_release, 4'b0001);
        check("b0_release_nopress", o_press, 4'b0000);
        check("b0_btn_low", o_btn, 4'b0010);
        i_btn[0] = 1'b1;
        tick(6);
        check("b0_repress", o_press, 4'b0001);
        i_ack = 4'b0001;
        tick(1);
        check("ack_vs_set", o_events, 4'b0001);
        tick(1);
        check("ack_alone", o_events, 4'b0000);
        check("int_still_high", o_int, 1'b1);
        i_ack = 4'b0000;
        tick(1);
        check("int_falls", o_int, 1'b0);

        // reset while button 2 is pending at count 2
        i_btn[2] = 1'b1;
        tick(4);
        #2 i_reset = 1'b1;
        #1;
        check("midrst_outputs", {o_btn, o_press, o_release, o_events, o_int}, 0);
        tick(2);
        i_reset = 1'b0;
        tick(5);
        check("midrst_not_early", o_btn, 4'b0000);
        tick(1);
        check("midrst_btn", o_btn, 4'b0111);
        check("midrst_press", o_press, 4'b0111);
        i_ack = 4'b0111;
        tick(2);
        i_ack = 4'b0000;
        tick(1);
        check("midrst_acked", {o_events, o_int}, 0);

        // button 3 held: repeats (if enabled), then release
        i_btn[3] = 1'b1;
        tick(6);
        check("b3_press_edge", o_press, 4'b1000);
        rep_mask = '0;
        n_other = 0;
        for (int i = 1; i <= 76; i++) begin
            if (i == 71) i_btn[3] = 1'b0;
            tick(1);
            if (o_press[3]) rep_mask[i] = 1'b1;
            if (o_press[2:0] != 3'b000) n_other++;
            if (i == 75) check("b3_still_high", o_btn[3], 1'b1);
        end
        rep_exp = '0;
`ifdef BTNDEBOUNCE_AUTOREPEAT_EN
        rep_exp[16] = 1'b1;
        rep_exp[32] = 1'b1;
        rep_exp[48] = 1'b1;
        rep_exp[64] = 1'b1;
`endif
        check("b3_repeat_offsets", rep_mask, rep_exp);
        check("b3_other_press", n_other, 0);
        check("b3_release", o_release, 4'b1000);
        check("b3_btn_low", o_btn, 4'b0111);
        acc = '0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            acc = acc | {o_press, o_release};
        end
        check("b3_after_release", acc, 0);
        check("b3_events", o_events, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
